// File: rtl/bsg_round_robin_arb_capture.sv
// Capture stage behind the round-robin arbiter: muxes the winner's payload,
// acknowledges it with yumi_o and buffers it in a 2-entry FIFO to the sink.
module bsg_round_robin_arb_capture #(
    parameter int inputs_p      = 64,
    parameter int width_p       = 32,
    parameter int lg_inputs_p   = $clog2(inputs_p),
    parameter int count_width_p = 16
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         v_i,
    input  logic [lg_inputs_p-1:0]       tag_i,
    input  logic [inputs_p-1:0]          sel_one_hot_i,
    input  logic [inputs_p*width_p-1:0]  data_i,
    output logic                         yumi_o,
    output logic                         v_o,
    output logic [width_p-1:0]           data_o,
    output logic [lg_inputs_p-1:0]       tag_o,
    input  logic                         ready_i,
    output logic [count_width_p-1:0]     count_o,
    output logic                         err_o
);

    localparam logic [inputs_p-1:0] one_lp = inputs_p'(1);

    logic [width_p-1:0]     data_mem [2];
    logic [lg_inputs_p-1:0] tag_mem  [2];
    logic [1:0]             entries;
    logic                   rd_ptr;
    logic                   wr_ptr;
    logic [count_width_p-1:0] count_r;
    logic                   err_r;

    logic [width_p-1:0]     mux_data;
    logic [inputs_p-1:0]    tag_dec;
    logic                   enq;
    logic                   deq;

    // Flat AND-OR keeps the select-to-data path shallow.
    always_comb begin
        mux_data = '0;
        for (int k = 0; k < inputs_p; k++) begin
            mux_data = mux_data
                     | (data_i[k*width_p +: width_p] & {width_p{sel_one_hot_i[k]}});
        end
    end

    assign tag_dec = one_lp << tag_i;
    assign yumi_o  = reset_n_i & v_i & (entries != 2'd2);
    assign enq     = yumi_o;
    assign v_o     = (entries != 2'd0);
    assign deq     = v_o & ready_i;
    assign data_o  = data_mem[rd_ptr];
    assign tag_o   = tag_mem[rd_ptr];
    assign count_o = count_r;
    assign err_o   = err_r;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            data_mem[0] <= '0;
            data_mem[1] <= '0;
            tag_mem[0]  <= '0;
            tag_mem[1]  <= '0;
            entries     <= 2'd0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count_r     <= '0;
            err_r       <= 1'b0;
        end else begin
            if (enq) begin
                data_mem[wr_ptr] <= mux_data;
                tag_mem[wr_ptr]  <= tag_i;
                wr_ptr           <= ~wr_ptr;
            end
            if (deq) begin
                rd_ptr  <= ~rd_ptr;
                count_r <= count_r + count_width_p'(1);
            end
            case ({enq, deq})
                2'b10:   entries <= entries + 2'd1;
                2'b01:   entries <= entries - 2'd1;
                default: entries <= entries;
            endcase
            if (v_i && (sel_one_hot_i != tag_dec))
                err_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bsg_round_robin_arb_capture.sv
// Randomized scoreboard bench for the arbiter capture FIFO.
module tb_bsg_round_robin_arb_capture;

    localparam int N  = 64;
    localparam int W  = 32;
    localparam int LG = 6;
    localparam int CW = 16;

    logic          clk;
    logic          reset_n;
    logic          v_in;
    logic [LG-1:0] tag_in;
    logic [N-1:0]  sel_in;
    logic [N*W-1:0] data_in;
    logic          ready_in;

    logic          yumi;
    logic          v_out;
    logic [W-1:0]  data_out;
    logic [LG-1:0] tag_out;
    logic [CW-1:0] count_out;
    logic          err_out;

    logic          yumi_s;
    logic          v_out_s;
    logic [W-1:0]  data_out_s;
    logic [LG-1:0] tag_out_s;
    logic [3:0]    count_out_s;
    logic          err_out_s;

    bsg_round_robin_arb_capture #(
        .inputs_p(N), .width_p(W), .lg_inputs_p(LG), .count_width_p(CW)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v_in), .tag_i(tag_in),
        .sel_one_hot_i(sel_in), .data_i(data_in), .yumi_o(yumi),
        .v_o(v_out), .data_o(data_out), .tag_o(tag_out),
        .ready_i(ready_in), .count_o(count_out), .err_o(err_out)
    );

    // Narrow-counter copy exercises counter wraparound quickly.
    bsg_round_robin_arb_capture #(
        .inputs_p(N), .width_p(W), .lg_inputs_p(LG), .count_width_p(4)
    ) dut_small (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v_in), .tag_i(tag_in),
        .sel_one_hot_i(sel_in), .data_i(data_in), .yumi_o(yumi_s),
        .v_o(v_out_s), .data_o(data_out_s), .tag_o(tag_out_s),
        .ready_i(ready_in), .count_o(count_out_s), .err_o(err_out_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [LG-1:0] tag;
        logic [W-1:0]  data;
    } entry_t;

    entry_t exp_q[$];
    int     occ   = 0;
    int     mcnt  = 0;
    bit     merr  = 0;
    bit     fresh = 0;
    bit     mon_en = 0;

    // Reference model: occupancy, delivered stream, transfer count, sticky error.
    always @(posedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            occ   = 0;
            mcnt  = 0;
            merr  = 0;
            fresh = 1;
        end else begin
            bit do_deq;
            bit do_enq;
            do_deq = (occ > 0) && ready_in;
            do_enq = v_in && (occ < 2);
            if (v_in && (sel_in != (64'd1 << tag_in)))
                merr = 1;
            if (do_enq) begin
                entry_t e;
                e.tag  = tag_in;
                e.data = '0;
                for (int k = 0; k < N; k++)
                    if (sel_in[k]) e.data = e.data | data_in[k*W +: W];
                exp_q.push_back(e);
                fresh = 0;
            end
            occ = occ - int'(do_deq) + int'(do_enq);
            if (do_deq) mcnt = (mcnt + 1) % 65536;
        end
    end

    // Monitor: compares DUT outputs mid-cycle, pops on each delivered entry.
    always @(negedge clk) begin
        if (mon_en) begin
            check("yumi",    64'(yumi),   64'(reset_n && v_in && occ < 2));
            check("yumi_s",  64'(yumi_s), 64'(reset_n && v_in && occ < 2));
            check("v_o",     64'(v_out),  64'(occ > 0));
            check("err_o",   64'(err_out), 64'(merr));
            check("count_o", 64'(count_out), 64'(mcnt));
            check("count_small", 64'(count_out_s), 64'(mcnt % 16));
            if (fresh && occ == 0) begin
                check("data_o_rst", 64'(data_out), 64'd0);
                check("tag_o_rst",  64'(tag_out),  64'd0);
            end
            if (v_out && ready_in) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 64'(v_out), 64'd0);
                end else begin
                    entry_t e;
                    e = exp_q.pop_front();
                    check("tag_o",  64'(tag_out),  64'(e.tag));
                    check("data_o", 64'(data_out), 64'(e.data));
                end
            end
        end
    end

    task automatic rand_data();
        for (int k = 0; k < N; k++) data_in[k*W +: W] = $urandom;
    endtask

    task automatic step(input logic rn, input logic v, input logic [LG-1:0] t,
                        input logic rdy);
        @(posedge clk);
        #1;
        rand_data();
        reset_n  = rn;
        v_in     = v;
        tag_in   = t;
        sel_in   = 64'd1 << t;
        ready_in = rdy;
    endtask

    initial begin
        reset_n  = 1'b0;
        v_in     = 1'b1;
        tag_in   = '0;
        sel_in   = 64'd1;
        ready_in = 1'b1;
        data_in  = '0;
        @(posedge clk);
        #1;
        mon_en = 1;
        step(1'b0, 1'b1, 6'd4, 1'b1);
        step(1'b1, 1'b0, 6'd0, 1'b1);

        step(1'b1, 1'b1, 6'd5, 1'b1);
        data_in[5*W +: W] = 32'hDEADBEEF;
        step(1'b1, 1'b0, 6'd0, 1'b1);
        step(1'b1, 1'b0, 6'd0, 1'b1);

        step(1'b1, 1'b1, 6'd1, 1'b0);
        step(1'b1, 1'b1, 6'd2, 1'b0);
        step(1'b1, 1'b1, 6'd3, 1'b0);
        step(1'b1, 1'b1, 6'd3, 1'b1);
        step(1'b1, 1'b1, 6'd3, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 6'd0, 1'b1);

        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, LG'(i), 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 6'd0, 1'b1);

        step(1'b1, 1'b1, 6'd3, 1'b1);
        sel_in = 64'h18;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, LG'(i + 20), 1'b1);
        step(1'b0, 1'b0, 6'd0, 1'b1);
        step(1'b1, 1'b0, 6'd0, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            logic rn;
            rn = ($urandom_range(0, 299) != 0);
            step(rn, 1'($urandom_range(0, 3) != 0), LG'($urandom),
                 1'($urandom_range(0, 2) != 0));
            case ($urandom_range(0, 59))
                0: sel_in = '0;
                1: sel_in = {$urandom, $urandom};
                default: ;
            endcase
        end

        step(1'b1, 1'b0, 6'd0, 1'b1);
        step(1'b1, 1'b0, 6'd0, 1'b1);
        step(1'b1, 1'b0, 6'd0, 1'b1);
        @(posedge clk);
        #1;
        mon_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
